// File: rtl/dmem_arbiter.sv
// Two-requester arbiter for the single-port data_mem: processor core vs host loader.
// Optional statistics outputs are enabled by defining DMEM_ARB_STATS_EN.
module dmem_arbiter #(
    parameter int AW       = 8,
    parameter int DW       = 8,
    parameter int CORE_RUN = 4
) (
    input  logic          CLK,
    input  logic          reset,
    input  logic          core_req,
    input  logic          core_we,
    input  logic [AW-1:0] core_addr,
    input  logic [DW-1:0] core_wdata,
    input  logic          core_halt,
    output logic          core_stall,
    output logic          core_valid,
    output logic [DW-1:0] core_rdata,
    input  logic          host_req,
    input  logic          host_we,
    input  logic [AW-1:0] host_addr,
    input  logic [DW-1:0] host_wdata,
    output logic          host_gnt,
    output logic          host_valid,
    output logic [DW-1:0] host_rdata,
`ifdef DMEM_ARB_STATS_EN
    output logic [15:0]   conflict_ct,
    output logic [7:0]    host_wait_max,
`endif
    output logic [AW-1:0] mem_addr,
    output logic          mem_we,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata
);
    localparam int RW = ($clog2(CORE_RUN + 1) > 3) ? $clog2(CORE_RUN + 1) : 3;
    localparam logic [RW-1:0] RUN_MAX = RW'(CORE_RUN);

    typedef enum logic {WIN_CORE, WIN_HOST} win_t;

    win_t          r_last_win;
    logic [RW-1:0] r_run_ct;
    logic          w_contested;
    logic          w_core_gnt;
    logic          w_host_gnt;

    // Host takes a contested slot on halt, or once the core has used up its run.
    always_comb begin
        w_contested = core_req & host_req;
        w_host_gnt  = host_req & (~core_req | core_halt |
                      ((r_last_win == WIN_CORE) && (r_run_ct >= RUN_MAX)));
        w_core_gnt  = core_req & ~w_host_gnt;
    end

    assign core_stall = core_req & ~w_core_gnt;
    assign host_gnt   = w_host_gnt;

    always_comb begin
        mem_addr  = '0;
        mem_we    = 1'b0;
        mem_wdata = '0;
        if (w_core_gnt) begin
            mem_addr  = core_addr;
            mem_we    = core_we;
            mem_wdata = core_wdata;
        end else if (w_host_gnt) begin
            mem_addr  = host_addr;
            mem_we    = host_we;
            mem_wdata = host_wdata;
        end
        if (reset) mem_we = 1'b0;
    end

    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            r_last_win <= WIN_HOST;
            r_run_ct   <= '0;
            core_valid <= 1'b0;
            host_valid <= 1'b0;
            core_rdata <= '0;
            host_rdata <= '0;
        end else begin
            core_valid <= w_core_gnt;
            host_valid <= w_host_gnt;
            if (w_core_gnt && !core_we) core_rdata <= mem_rdata;
            if (w_host_gnt && !host_we) host_rdata <= mem_rdata;
            if (w_host_gnt) begin
                r_run_ct   <= '0;
                r_last_win <= WIN_HOST;
            end else if (w_core_gnt && w_contested) begin
                if (r_run_ct < RUN_MAX) r_run_ct <= r_run_ct + 1'b1;
                r_last_win <= WIN_CORE;
            end else begin
                r_run_ct <= '0;
            end
        end
    end

`ifdef DMEM_ARB_STATS_EN
    logic [7:0] r_wait_cur;
    logic [7:0] w_wait_nxt;

    assign w_wait_nxt = (r_wait_cur == 8'hFF) ? r_wait_cur : r_wait_cur + 8'd1;

    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            conflict_ct   <= '0;
            host_wait_max <= '0;
            r_wait_cur    <= '0;
        end else begin
            if (w_contested && conflict_ct != 16'hFFFF) conflict_ct <= conflict_ct + 16'd1;
            if (host_req && !w_host_gnt) begin
                r_wait_cur <= w_wait_nxt;
                if (w_wait_nxt > host_wait_max) host_wait_max <= w_wait_nxt;
            end else begin
                r_wait_cur <= '0;
            end
        end
    end
`endif

endmodule
